// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus master: FSM encoding,
// default phase timing and the RTC chip register map.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_STB,
        A_GAP,
        D_STB,
        D_GAP,
        FIN
    } seq_state_t;

    localparam int T_PH_DEF  = 4;
    localparam int T_GAP_DEF = 2;

    // RTC chip register map
    localparam logic [7:0] RTC_REG_SEC      = 8'h00;
    localparam logic [7:0] RTC_REG_MIN      = 8'h01;
    localparam logic [7:0] RTC_REG_HOUR     = 8'h02;
    localparam logic [7:0] RTC_REG_DAY      = 8'h03;
    localparam logic [7:0] RTC_REG_WDAY     = 8'h04;
    localparam logic [7:0] RTC_REG_MON      = 8'h05;
    localparam logic [7:0] RTC_REG_YEAR     = 8'h06;
    localparam logic [7:0] RTC_REG_TMR_CTRL = 8'h07;
    localparam logic [7:0] RTC_REG_TMR_CNT  = 8'h08;
    localparam logic [7:0] RTC_REG_IRQ_STAT = 8'h09;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter with a zero flag; used for bus phase timing and the
// IRQ hold timeout.
module rtc_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             cnt <= '0;
        else if (load)        cnt <= load_val;
        else if (cnt != '0)   cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// AD/CS/RD/WR burst master for the external RTC plus IRQ conditioning.
// Optional macro RTC_IRQ_TIMEOUT_EN adds a self-clear of irq_pending after IRQ_HOLD clocks.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NREG     = 9,
    parameter int T_PH     = T_PH_DEF,
    parameter int T_GAP    = T_GAP_DEF,
    parameter int IRQ_HOLD = 600
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       wr_nrd,
    input  logic [DATA_W-1:0]          base_addr,
    input  logic [$clog2(NREG+1)-1:0]  count,
    input  logic [NREG*DATA_W-1:0]     wdata,
    output logic                       busy,
    output logic                       done,
    output logic [NREG*DATA_W-1:0]     rdata,
    output logic                       ad,
    output logic                       cs_n,
    output logic                       rd_n,
    output logic                       wr_n,
    output logic                       bus_oe,
    output logic [DATA_W-1:0]          bus_dout,
    input  logic [DATA_W-1:0]          bus_din,
    input  logic                       irq_n,
    input  logic                       irq_ack,
    output logic                       irq_pending
);

    localparam int CW   = $clog2(NREG+1);
    localparam int TMAX = (T_PH > T_GAP) ? T_PH : T_GAP;
    localparam int TW   = $clog2(TMAX+1);

    seq_state_t                state, state_d;
    logic [DATA_W-1:0]         addr;
    logic [CW-1:0]             idx, left, cnt_clamp;
    logic                      wr_q;
    logic [NREG*DATA_W-1:0]    wdata_q;
    logic                      tmr_load, tmr_zero;
    logic [TW-1:0]             tmr_val;

    assign cnt_clamp = (count > CW'(NREG)) ? CW'(NREG) : count;

    rtc_phase_timer #(.W(TW)) u_ph_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // count=0 passes through one idle-looking D_GAP clock so done lands 2 clocks after start
    always_comb begin
        state_d  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: if (start) begin
                tmr_load = 1'b1;
                if (cnt_clamp == '0) state_d = D_GAP;
                else begin
                    state_d = A_STB;
                    tmr_val = TW'(T_PH-1);
                end
            end
            A_STB: if (tmr_zero) begin
                state_d = A_GAP; tmr_load = 1'b1; tmr_val = TW'(T_GAP-1);
            end
            A_GAP: if (tmr_zero) begin
                state_d = D_STB; tmr_load = 1'b1; tmr_val = TW'(T_PH-1);
            end
            D_STB: if (tmr_zero) begin
                state_d = D_GAP; tmr_load = 1'b1; tmr_val = TW'(T_GAP-1);
            end
            D_GAP: if (tmr_zero) begin
                if (left <= CW'(1)) state_d = FIN;
                else begin
                    state_d = A_STB; tmr_load = 1'b1; tmr_val = TW'(T_PH-1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr    <= '0;
            idx     <= '0;
            left    <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            if (state == IDLE && start) begin
                wr_q    <= wr_nrd;
                addr    <= base_addr;
                left    <= cnt_clamp;
                idx     <= '0;
                wdata_q <= wdata;
            end
            if (state == D_STB && tmr_zero && !wr_q)
                rdata[idx*DATA_W +: DATA_W] <= bus_din;
            if (state == D_GAP && tmr_zero && left != '0) begin
                addr <= addr + 1'b1;
                idx  <= idx + 1'b1;
                left <= left - 1'b1;
            end
        end
    end

    // Bus pins decode straight from state so reset releases them without a clock
    always_comb begin
        ad       = 1'b1;
        cs_n     = 1'b1;
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        bus_oe   = 1'b0;
        bus_dout = '0;
        case (state)
            A_STB: begin
                ad = 1'b0; cs_n = 1'b0; wr_n = 1'b0; bus_oe = 1'b1; bus_dout = addr;
            end
            A_GAP: begin
                ad = 1'b0; bus_oe = 1'b1; bus_dout = addr;
            end
            D_STB: begin
                cs_n = 1'b0;
                if (wr_q) begin
                    wr_n = 1'b0; bus_oe = 1'b1; bus_dout = wdata_q[idx*DATA_W +: DATA_W];
                end else begin
                    rd_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE) && (state != FIN);
    assign done = (state == FIN);

    logic irq_s1, irq_s2, irq_s3, irq_fall, irq_clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {irq_s1, irq_s2, irq_s3} <= 3'b111;
        else      {irq_s1, irq_s2, irq_s3} <= {irq_n, irq_s1, irq_s2};
    end

    assign irq_fall = irq_s3 & ~irq_s2;

`ifdef RTC_IRQ_TIMEOUT_EN
    localparam int HW = $clog2(IRQ_HOLD+1);
    logic hold_zero;

    rtc_phase_timer #(.W(HW)) u_irq_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (irq_fall),
        .load_val (HW'(IRQ_HOLD-1)),
        .zero     (hold_zero)
    );

    assign irq_clr = irq_ack | (irq_pending & hold_zero);
`else
    assign irq_clr = irq_ack;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          irq_pending <= 1'b0;
        else if (irq_fall) irq_pending <= 1'b1;
        else if (irq_clr)  irq_pending <= 1'b0;
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: bursts, boundaries, reset abort and IRQ.
module tb_rtc_bus_sequencer;

    localparam int DW = 8;
    localparam int NR = 9;
    localparam int CW = $clog2(NR+1);

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, wr_nrd = 1'b0;
    logic irq_n = 1'b1, irq_ack = 1'b0;
    logic [DW-1:0] base_addr = '0, bus_din, bus_dout;
    logic [CW-1:0] count = '0;
    logic [NR*DW-1:0] wdata = '0, rdata;
    logic busy, done, ad, cs_n, rd_n, wr_n, bus_oe, irq_pending;

    always #5 clk = ~clk;

    rtc_bus_sequencer #(.DATA_W(DW), .NREG(NR), .T_PH(4), .T_GAP(2), .IRQ_HOLD(10)) dut (
        .clk(clk), .rst(rst), .start(start), .wr_nrd(wr_nrd), .base_addr(base_addr),
        .count(count), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .ad(ad), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .bus_oe(bus_oe),
        .bus_dout(bus_dout), .bus_din(bus_din), .irq_n(irq_n), .irq_ack(irq_ack),
        .irq_pending(irq_pending)
    );

    // Bus monitor: logs address/data phases, strobe activity and done pulses
    logic [7:0] addr_log [64];
    logic [7:0] data_log [64];
    logic       data_oe  [64];
    logic [7:0] rd_vals  [64];
    int n_addr = 0, n_data = 0, n_dph = 0, n_stb = 0, n_oe_bad = 0, n_done = 0;
    logic prev_cs = 1'b1, prev_ad = 1'b1;

    assign bus_din = rd_vals[n_dph % 64];

    always @(negedge clk) begin
        if (!cs_n && prev_cs) begin
            if (!ad) begin addr_log[n_addr % 64] = bus_dout; n_addr++; end
            else begin data_log[n_data % 64] = bus_dout; data_oe[n_data % 64] = bus_oe; n_data++; end
        end
        if (!prev_cs && cs_n && prev_ad) n_dph++;
        if (!cs_n || !rd_n || !wr_n) n_stb++;
        if (!cs_n && ad && !rd_n && bus_oe) n_oe_bad++;
        if (done) n_done++;
        prev_cs = cs_n;
        prev_ad = ad;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one start, return in the done clock with c = clocks since start (first busy clock = 1)
    task automatic go(input logic wr, input logic [7:0] base, input logic [CW-1:0] cnt, output int c);
        wr_nrd = wr; base_addr = base; count = cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        c = 1;
        while (!done && c < 300) begin tick; c++; end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, a0, d0, r0, s0, k0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ad", ad, 1);
        chk("rst_strobes", {cs_n, rd_n, wr_n}, 3'b111);
        chk("rst_oe", bus_oe, 0);
        chk("rst_dout", bus_dout, 0);
        chk("rst_irq", irq_pending, 0);
        repeat (2) tick;
        rst = 1'b1;
        tick;

        // Write burst 0x21 x3
        wdata = '0;
        wdata[7:0] = 8'h12; wdata[15:8] = 8'h34; wdata[23:16] = 8'h56;
        a0 = n_addr; d0 = n_data;
        go(1'b1, 8'h21, 4'd3, c);
        chk("wr_done_clk", c, 37);
        chk("wr_busy_fin", busy, 0);
        tick;
        chk("wr_naddr", n_addr - a0, 3);
        chk("wr_addrs", {addr_log[a0 % 64], addr_log[(a0+1) % 64], addr_log[(a0+2) % 64]}, 24'h212223);
        chk("wr_data", {data_log[d0 % 64], data_log[(d0+1) % 64], data_log[(d0+2) % 64]}, 24'h123456);
        chk("wr_data_oe", {data_oe[d0 % 64], data_oe[(d0+1) % 64], data_oe[(d0+2) % 64]}, 3'b111);
        chk("wr_rdata_untouched", rdata, 0);

        // count=0
        s0 = n_stb;
        go(1'b0, 8'h50, 4'd0, c);
        chk("cnt0_done_clk", c, 2);
        tick;
        chk("cnt0_no_strobe", n_stb - s0, 0);

        // count=15 clamps to 9 (read, fills rdata)
        r0 = n_dph;
        for (int i = 0; i < 9; i++) rd_vals[(r0+i) % 64] = 8'hA0 + 8'(i);
        a0 = n_addr;
        go(1'b0, 8'h30, 4'd15, c);
        chk("clamp_done_clk", c, 109);
        tick;
        chk("clamp_naddr", n_addr - a0, 9);
        chk("clamp_last_addr", addr_log[(a0+8) % 64], 8'h38);
        chk("clamp_rdata0", rdata[7:0], 8'hA0);
        chk("clamp_rdata8", rdata[71:64], 8'hA8);

        // Read burst 0x41 x2
        r0 = n_dph; a0 = n_addr; d0 = n_data;
        rd_vals[r0 % 64] = 8'h59; rd_vals[(r0+1) % 64] = 8'h07;
        go(1'b0, 8'h41, 4'd2, c);
        chk("rd_done_clk", c, 25);
        tick;
        chk("rd_word0", rdata[7:0], 8'h59);
        chk("rd_word1", rdata[15:8], 8'h07);
        chk("rd_word2_kept", rdata[23:16], 8'hA2);
        chk("rd_word8_kept", rdata[71:64], 8'hA8);
        chk("rd_addrs", {addr_log[a0 % 64], addr_log[(a0+1) % 64]}, 16'h4142);
        chk("rd_oe_low", {data_oe[d0 % 64], data_oe[(d0+1) % 64]}, 2'b00);
        chk("rd_oe_never", n_oe_bad, 0);

        // Address wrap
        a0 = n_addr;
        go(1'b1, 8'hFF, 4'd2, c);
        tick;
        chk("wrap_addrs", {addr_log[a0 % 64], addr_log[(a0+1) % 64]}, 16'hFF00);

        // Start while busy and in the FIN clock are ignored
        k0 = n_done;
        wr_nrd = 1'b1; base_addr = 8'h60; count = 4'd1;
        start = 1'b1; tick; start = 1'b0; c = 1;
        repeat (4) begin tick; c++; end
        start = 1'b1; tick; start = 1'b0; c++;
        while (!done && c < 300) begin tick; c++; end
        chk("busy_start_done_clk", c, 13);
        start = 1'b1; tick; start = 1'b0;
        chk("fin_start_ignored", busy, 0);
        repeat (30) tick;
        chk("one_done_per_start", n_done - k0, 1);

        // Reset during D_STB of transfer 2
        k0 = n_done;
        wr_nrd = 1'b0; base_addr = 8'h70; count = 4'd3;
        start = 1'b1; tick; start = 1'b0;
        repeat (19) tick;
        chk("pre_rst_strobe", {cs_n, rd_n}, 2'b00);
        #2 rst = 1'b0;
        #1;
        chk("async_rel_strobes", {cs_n, rd_n, wr_n}, 3'b111);
        chk("async_rel_oe", bus_oe, 0);
        chk("async_rel_busy", busy, 0);
        repeat (2) tick;
        rst = 1'b1;
        repeat (40) tick;
        chk("rst_no_done", n_done - k0, 0);
        chk("rst_rdata_cleared", rdata, 0);
        wdata[7:0] = 8'hC3;
        a0 = n_addr; d0 = n_data;
        go(1'b1, 8'h10, 4'd1, c);
        chk("post_rst_done_clk", c, 13);
        tick;
        chk("post_rst_xfer", {addr_log[a0 % 64], data_log[d0 % 64]}, 16'h10C3);

        // IRQ
        irq_n = 1'b0;
        repeat (2) tick;
        chk("irq_sync_delay", irq_pending, 0);
        tick;
        chk("irq_set", irq_pending, 1);
`ifdef RTC_IRQ_TIMEOUT_EN
        repeat (9) tick;
        chk("irq_hold", irq_pending, 1);
        tick;
        chk("irq_timeout", irq_pending, 0);
`else
        repeat (15) tick;
        chk("irq_held", irq_pending, 1);
        irq_ack = 1'b1; tick; irq_ack = 1'b0;
        chk("irq_ack_clear", irq_pending, 0);
`endif
        irq_n = 1'b1;
        repeat (4) tick;
        chk("irq_rise_no_set", irq_pending, 0);
        irq_n = 1'b0;
        repeat (2) tick;
        irq_ack = 1'b1; tick; irq_ack = 1'b0;
        chk("irq_set_wins", irq_pending, 1);
        irq_ack = 1'b1; tick; irq_ack = 1'b0;
        chk("irq_ack_clear2", irq_pending, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
